uart_tx_fifo_ctrl: RTL
======================

# uart_tx_fifo_ctrl

Byte buffer and sequencer upstream of the UART transmitter. Producers push bytes into an internal synchronous FIFO. The block pops one byte at a time and drives the transmitter's level-enable / done handshake (`tx_en_sig`, `tx_data`, `tx_done`), so bytes leave back-to-back without software pacing. It holds no baud logic; bit timing belongs entirely to the transmitter.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `AW`, 4: address width, log2(DEPTH).

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_en`  in  1  push request; ignored when `full`
- `wr_data`  in  8  byte to push
- `full`  out  1  FIFO holds DEPTH bytes
- `empty`  out  1  FIFO holds 0 bytes
- `count`  out  AW+1  bytes currently buffered, 0..DEPTH
- `overflow`  out  1  one-cycle pulse: `wr_en` while `full`, byte dropped
- `busy`  out  1  high while a byte is handed to the transmitter (state SEND)
- `tx_en_sig`  out  1  transmitter enable, held high for one whole frame
- `tx_data`  out  8  byte for the transmitter, stable while `tx_en_sig` high
- `tx_done`  in  1  one-cycle frame-complete pulse from the transmitter

## Operation
- FIFO: `mem[DEPTH]`, write and read pointers AW+1 bits wide. The extra bit is the wrap flag.
  - `empty` = pointers equal.
  - `full` = addresses equal and wrap bits differ.
  - `count` = wr_ptr − rd_ptr, modulo 2^(AW+1).
  - All flags are registered/derived from pre-edge state.
- Push: on an edge where `wr_en` is high and `full` is low, write `mem[wr_ptr]` and increment wr_ptr.
  - When `wr_en` and `full` are both high: no write, and `overflow` is high for the following cycle.
- FSM, 2 states:
  - IDLE: if `!empty`, then `tx_data <= mem[rd_ptr]`, rd_ptr++, `tx_en_sig <= 1`, go to SEND. Otherwise stay.
  - SEND: `tx_en_sig` is held at 1 and `tx_data` is held. When `tx_done` = 1, `tx_en_sig <= 0` and go to IDLE.
  - `busy` = (state == SEND).
- `tx_en_sig` falls on the same edge on which the transmitter clears its done pulse and rewinds. This gives at least one cycle low between frames, so no byte is sent twice.
- Simultaneous push and pop on one edge:
  - Both take effect; `count` is unchanged.
  - Push while full is rejected even if a pop occurs on the same edge.
  - Pop while empty is impossible, even if a push occurs on the same edge.
- `tx_done` seen in IDLE is ignored.
- Reset (any cycle, including mid-frame): pointers 0, state IDLE, `tx_en_sig` 0, `tx_data` 0x00, `overflow` 0. Buffered bytes are discarded; `mem` contents are not cleared.
- `rst` must be driven together with the transmitter's reset (inverted). A controller-only reset mid-frame leaves the transmitter frozen, because its state only advances while enabled.

## Timing
- Reset values: `full`=0, `empty`=1, `count`=0, `overflow`=0, `busy`=0, `tx_en_sig`=0, `tx_data`=0x00.
- Write latency: byte pushed at edge N → `empty` low after N → `tx_en_sig` high after N+1.
- Transmitter loads at the first edge with enable high. Start bit appears on the line after N+3.
- Frame release: `tx_done` high in cycle M → `tx_en_sig` low after edge M → earliest re-assert after edge M+1.
- Rising-edge spacing of `tx_en_sig` for back-to-back bytes with the transmitter attached is 10·BPS+4 cycles (4344 at BPS=434).
- `count` and `full` update on the edge following a push or pop. There is no combinational path from `wr_en` to `full`.

## Test plan
- Reset, then idle 20 cycles → `empty`=1, `count`=0, `tx_en_sig`=0, `tx_data`=0x00 throughout.
- Push 0x55 at edge N with transmitter (BPS=8) attached → `tx_en_sig` high after N+1. Line carries 0,1,0,1,0,1,0,1,0,1 at 8 cycles/bit. `tx_en_sig` falls the edge after `tx_done`. Afterwards `empty`=1 and `busy`=0.
- Push 0x01, 0x02, 0x03 on consecutive edges → three frames in order. `tx_en_sig` rises are spaced 84 cycles (BPS=8). `tx_en_sig` is low exactly 1 cycle between frames.
- Stub `tx_done` never asserted; push 17 bytes with DEPTH=16:
  - 1st byte moves to `tx_data`, bytes 2–17 fill the FIFO, `full`=1, `count`=16.
  - An 18th push gives `overflow` high for 1 cycle and `count` stays 16.
- With `count`=16, push and `tx_done` on the same cycle → pop occurs and push is rejected. `count`=15, then next push accepted → 16. Read pointer wraps, and byte order is preserved across the wrap.
- Assert `rst` mid-frame with 3 bytes buffered → next cycle `tx_en_sig`=0, `count`=0, state IDLE. Transmitter reset alongside. A push afterward sends the new byte intact.

Source files
------------

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: byte FIFO plus a two-state sequencer that feeds a UART
// transmitter through a level-enable / done-pulse handshake. Bit timing lives
// entirely in the transmitter; this block only decides which byte goes next.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no byte handed out; pops the FIFO head as soon as it is non-empty
// SEND  | tx_en_sig held high, tx_data held, waiting for tx_done
module uart_tx_fifo_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          busy,
   output logic          tx_en_sig,
   output logic [7:0]    tx_data,
   input  logic          tx_done
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          push;
   logic          pop;

   // Flags come straight from the registered pointers; the top pointer bit is
   // the wrap flag that tells full apart from empty when addresses match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign count = wr_ptr - rd_ptr;
   assign busy  = (state == SEND);

   // A full FIFO rejects the push even if a pop lands on the same edge, and a
   // pop needs data present before the edge, so neither depends on the other.
   assign push = wr_en && !full;
   assign pop  = (state == IDLE) && !empty;

   // Storage array; left uninitialised on reset, pointers alone define content.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Write pointer and the one-cycle overflow flag for dropped bytes.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= wr_en && full;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
      end
   end

   // Sequencer: pop one byte into tx_data, hold enable until the frame ends.
   // Enable drops on the edge that sees tx_done, which guarantees at least one
   // low cycle before the next byte so the transmitter rewinds cleanly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rd_ptr    <= '0;
         tx_en_sig <= 1'b0;
         tx_data   <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data   <= mem[rd_ptr[AW-1:0]];
                  rd_ptr    <= rd_ptr + 1'b1;
                  tx_en_sig <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (tx_done) begin
                  tx_en_sig <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               tx_en_sig <= 1'b0;
            end
         endcase
      end
   end

endmodule
